branch_cache_ctrl: RTL and testbench

Sequencer and arbiter for the two-way branch cache. It takes branch-resolution updates from the execute stage and holds them in a small FIFO. It issues them to the cache jump port only when they do not collide with a fetch search on the same set, and it sequences cache flushes after reset and pipeline flush. It sits between fetch, execute and `branch_cache`. The cache itself is unchanged.

---
 rtl/branch_pkg.sv | 28 ++
 rtl/branch_upd_fifo.sv | 65 ++++++
 rtl/branch_cache_ctrl.sv | 131 +++++++++++++
 tb/tb_branch_cache_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch cache sequencer.
package branch_pkg;

    // Sequencer states; encoding is fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } bc_state_e;

    // One resolved-branch update: {hit, target, inst_addr}.
    localparam int UPD_W = 65;

    typedef struct packed {
        logic        hit;
        logic [31:0] target;
        logic [31:0] inst_addr;
    } upd_entry_t;

    // Set index of the two-way cache is taken from word-address bits [4:2].
    localparam int SET_LO = 2;
    localparam int SET_HI = 4;

    function automatic logic [SET_HI-SET_LO:0] set_idx(input logic [31:0] addr);
        return addr[SET_HI:SET_LO];
    endfunction

endpackage

// File: rtl/branch_upd_fifo.sv
// Synchronous FIFO holding pending branch-cache updates.
// Push and pop arrive pre-qualified from the arbiter; a push while full is
// only issued together with a pop, so occupancy never exceeds DEPTH.
module branch_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                     iCLOCK,
    input  logic                     inRESET,
    input  logic                     iCLEAR,
    input  logic                     iPUSH,
    input  logic [WIDTH-1:0]         iDATA,
    input  logic                     iPOP,
    output logic [WIDTH-1:0]         oDATA,
    output logic                     oFULL,
    output logic                     oEMPTY,
    output logic [$clog2(DEPTH):0]   oCOUNT
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW:0]      cnt_q,  cnt_d;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (iCLEAR) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (iPUSH) wptr_d = wptr_q + 1'b1;
            if (iPOP)  rptr_d = rptr_q + 1'b1;
            cnt_d = cnt_q + (PW+1)'(iPUSH) - (PW+1)'(iPOP);
        end
    end

    // Control state registers.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy gates whether an entry is meaningful.
    always_ff @(posedge iCLOCK) begin
        if (iPUSH && !iCLEAR) mem_q[wptr_q] <= iDATA;
    end

    assign oDATA  = mem_q[rptr_q];
    assign oCOUNT = cnt_q;
    assign oFULL  = (cnt_q == (PW+1)'(DEPTH));
    assign oEMPTY = (cnt_q == '0);

endmodule

// File: rtl/branch_cache_ctrl.sv
// Sequencer/arbiter in front of the two-way branch cache: queues execute
// updates, issues them on the jump port when they do not collide with the
// fetch search on the same set, and sequences cache flushes.
module branch_cache_ctrl
    import branch_pkg::*;
#(
    parameter int UPD_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iFLUSH,
    input  logic        iFETCH_REQ,
    input  logic [31:0] iFETCH_ADDR,
    output logic        oFETCH_STALL,
    input  logic        iEXE_UPD_VALID,
    input  logic        iEXE_UPD_HIT,
    input  logic [31:0] iEXE_UPD_ADDR,
    input  logic [31:0] iEXE_UPD_INST_ADDR,
    output logic        oEXE_UPD_BUSY,
    output logic        oUPD_OVERFLOW,
    output logic        oBC_SEARCH_STB,
    output logic [31:0] oBC_SEARCH_INST_ADDR,
    output logic        oBC_JUMP_STB,
    output logic        oBC_JUMP_HIT,
    output logic [31:0] oBC_JUMP_ADDR,
    output logic [31:0] oBC_JUMP_INST_ADDR,
    output logic        oBC_FLUSH
);
    localparam int         CW    = $clog2(UPD_FIFO_DEPTH);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    bc_state_e  state_q, state_d;
    logic       flush_q, flush_d;
    logic [7:0] starve_q, starve_d;
    logic       ovf_q, ovf_d;

    logic [UPD_W-1:0] fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic [CW:0]      fifo_count;
    upd_entry_t       head, wr_entry;

    logic in_run, flush_req, conflict, forced, issue, defer;
    logic fifo_clr, push, drop;

    assign head     = upd_entry_t'(fifo_rdata);
    assign wr_entry = '{hit: iEXE_UPD_HIT, target: iEXE_UPD_ADDR,
                        inst_addr: iEXE_UPD_INST_ADDR};

    branch_upd_fifo #(
        .DEPTH (UPD_FIFO_DEPTH),
        .WIDTH (UPD_W)
    ) u_fifo (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .iCLEAR  (fifo_clr),
        .iPUSH   (push),
        .iDATA   (wr_entry),
        .iPOP    (issue),
        .oDATA   (fifo_rdata),
        .oFULL   (fifo_full),
        .oEMPTY  (fifo_empty),
        .oCOUNT  (fifo_count)
    );

    // Arbitration between fetch search and the queued jump update.
    always_comb begin
        in_run    = (state_q == ST_RUN);
        flush_req = iFLUSH | iRESET_SYNC;
        conflict  = iFETCH_REQ && (set_idx(iFETCH_ADDR) == set_idx(head.inst_addr));
        forced    = in_run && !fifo_empty && conflict && (starve_q == LIMIT);
        issue     = in_run && !fifo_empty && (!conflict || forced);
        defer     = in_run && !fifo_empty && conflict && !forced;
        // A flush seen in RUN wins over a same-edge enqueue.
        fifo_clr  = !in_run || flush_req;
        // Full is tolerated when the head leaves in the same cycle.
        push      = in_run && iEXE_UPD_VALID && (!fifo_full || issue);
        drop      = in_run && iEXE_UPD_VALID && fifo_full && !issue;
    end

    // Next-state for FSM, flush output, starvation counter and overflow flag.
    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        starve_d = starve_q;
        ovf_d    = ovf_q | drop;
        case (state_q)
            ST_INIT:  state_d = ST_RUN;
            ST_RUN:   state_d = flush_req ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_d = flush_req ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_INIT;
        endcase
        flush_d = (state_d != ST_RUN);
        if (fifo_clr || issue)
            starve_d = '0;
        else if (defer && starve_q != 8'hFF)
            starve_d = starve_q + 8'd1;
    end

    // Sequencer registers; cache flush is asserted straight out of reset.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q  <= ST_INIT;
            flush_q  <= 1'b1;
            starve_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            starve_q <= starve_d;
            ovf_q    <= ovf_d;
        end
    end

    // Cache-side outputs are combinational so the cache samples them this edge.
    always_comb begin
        oBC_SEARCH_STB = in_run && iFETCH_REQ && !forced;
        oBC_JUMP_STB   = issue;
        oFETCH_STALL   = in_run ? forced : iFETCH_REQ;
    end

    assign oBC_SEARCH_INST_ADDR = iFETCH_ADDR;
    assign oBC_JUMP_HIT         = head.hit;
    assign oBC_JUMP_ADDR        = head.target;
    assign oBC_JUMP_INST_ADDR   = head.inst_addr;
    assign oBC_FLUSH            = flush_q;
    assign oEXE_UPD_BUSY        = fifo_full;
    assign oUPD_OVERFLOW        = ovf_q;

endmodule

// File: tb/tb_branch_cache_ctrl.sv
// Self-checking bench for branch_cache_ctrl: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_branch_cache_ctrl;
    localparam int D = 4;
    localparam int L = 8;

    logic        iCLOCK = 1'b0;
    logic        inRESET = 1'b0;
    logic        iRESET_SYNC = 1'b0;
    logic        iFLUSH = 1'b0;
    logic        iFETCH_REQ = 1'b0;
    logic [31:0] iFETCH_ADDR = '0;
    logic        oFETCH_STALL;
    logic        iEXE_UPD_VALID = 1'b0;
    logic        iEXE_UPD_HIT = 1'b0;
    logic [31:0] iEXE_UPD_ADDR = '0;
    logic [31:0] iEXE_UPD_INST_ADDR = '0;
    logic        oEXE_UPD_BUSY;
    logic        oUPD_OVERFLOW;
    logic        oBC_SEARCH_STB;
    logic [31:0] oBC_SEARCH_INST_ADDR;
    logic        oBC_JUMP_STB;
    logic        oBC_JUMP_HIT;
    logic [31:0] oBC_JUMP_ADDR;
    logic [31:0] oBC_JUMP_INST_ADDR;
    logic        oBC_FLUSH;

    branch_cache_ctrl #(.UPD_FIFO_DEPTH(D), .STARVE_LIMIT(L)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC), .iFLUSH(iFLUSH),
        .iFETCH_REQ(iFETCH_REQ), .iFETCH_ADDR(iFETCH_ADDR), .oFETCH_STALL(oFETCH_STALL),
        .iEXE_UPD_VALID(iEXE_UPD_VALID), .iEXE_UPD_HIT(iEXE_UPD_HIT),
        .iEXE_UPD_ADDR(iEXE_UPD_ADDR), .iEXE_UPD_INST_ADDR(iEXE_UPD_INST_ADDR),
        .oEXE_UPD_BUSY(oEXE_UPD_BUSY), .oUPD_OVERFLOW(oUPD_OVERFLOW),
        .oBC_SEARCH_STB(oBC_SEARCH_STB), .oBC_SEARCH_INST_ADDR(oBC_SEARCH_INST_ADDR),
        .oBC_JUMP_STB(oBC_JUMP_STB), .oBC_JUMP_HIT(oBC_JUMP_HIT),
        .oBC_JUMP_ADDR(oBC_JUMP_ADDR), .oBC_JUMP_INST_ADDR(oBC_JUMP_INST_ADDR),
        .oBC_FLUSH(oBC_FLUSH)
    );

    always #5 iCLOCK = ~iCLOCK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        hit;
        logic [31:0] tgt;
        logic [31:0] inst;
    } ent_t;

    localparam int M_INIT = 0, M_RUN = 1, M_FLUSH = 2;
    ent_t mq[$];
    int   mst  = M_INIT;
    int   mcnt = 0;
    bit   movf = 0;

    function automatic bit same_set(input logic [31:0] a, input logic [31:0] b);
        return ((a >> 2) % 8) == ((b >> 2) % 8);
    endfunction

    // Model advances on each clock edge from the inputs of the ending cycle.
    initial forever begin
        bit fl, ne, cf, pop, full;
        @(posedge iCLOCK or negedge inRESET);
        if (!inRESET) begin
            mq.delete(); mst = M_INIT; mcnt = 0; movf = 0;
        end else begin
            fl = iFLUSH || iRESET_SYNC;
            if (mst != M_RUN) begin
                mq.delete(); mcnt = 0;
                mst = (mst == M_FLUSH && fl) ? M_FLUSH : M_RUN;
            end else begin
                ne   = mq.size() > 0;
                cf   = ne && iFETCH_REQ && same_set(iFETCH_ADDR, mq[0].inst);
                pop  = ne && (!cf || mcnt == L);
                full = mq.size() == D;
                if (pop) begin
                    void'(mq.pop_front()); mcnt = 0;
                end else if (cf) mcnt++;
                if (iEXE_UPD_VALID) begin
                    if (!full || pop) mq.push_back('{iEXE_UPD_HIT, iEXE_UPD_ADDR, iEXE_UPD_INST_ADDR});
                    else movf = 1;
                end
                if (fl) begin
                    mq.delete(); mcnt = 0; mst = M_FLUSH;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        bit ne, cf, fo;
        @(negedge iCLOCK);
        ne = mq.size() > 0;
        cf = ne && iFETCH_REQ && same_set(iFETCH_ADDR, mq[0].inst);
        fo = cf && mcnt == L;
        if (mst != M_RUN) begin
            chk("m_flush", oBC_FLUSH, 1);
            chk("m_search_stb", oBC_SEARCH_STB, 0);
            chk("m_jump_stb", oBC_JUMP_STB, 0);
            chk("m_stall", oFETCH_STALL, iFETCH_REQ);
        end else begin
            chk("m_flush", oBC_FLUSH, 0);
            chk("m_search_stb", oBC_SEARCH_STB, iFETCH_REQ && !fo);
            chk("m_jump_stb", oBC_JUMP_STB, ne && (!cf || fo));
            chk("m_stall", oFETCH_STALL, fo);
            if (iFETCH_REQ) chk("m_search_addr", oBC_SEARCH_INST_ADDR, iFETCH_ADDR);
        end
        if (ne) begin
            chk("m_jump_hit", oBC_JUMP_HIT, mq[0].hit);
            chk("m_jump_addr", oBC_JUMP_ADDR, mq[0].tgt);
            chk("m_jump_inst", oBC_JUMP_INST_ADDR, mq[0].inst);
        end
        chk("m_busy", oEXE_UPD_BUSY, mq.size() == D);
        chk("m_ovf", oUPD_OVERFLOW, movf);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge iCLOCK); #1;
    endtask

    task automatic upd(input logic v, input logic h, input logic [31:0] t, input logic [31:0] ia);
        iEXE_UPD_VALID = v; iEXE_UPD_HIT = h; iEXE_UPD_ADDR = t; iEXE_UPD_INST_ADDR = ia;
    endtask

    initial begin
        int defers, fl_cyc, jmp_cyc;
        bit got;

        // Reset and release: one INIT cycle with the cache flush high.
        repeat (2) @(posedge iCLOCK);
        #1 inRESET = 1'b1;
        @(negedge iCLOCK);
        chk("rst_flush", oBC_FLUSH, 1);
        chk("rst_busy", oEXE_UPD_BUSY, 0);
        chk("rst_jump", oBC_JUMP_STB, 0);
        step();
        @(negedge iCLOCK);
        chk("run_flush", oBC_FLUSH, 0);

        // Single update, no fetch: issued the cycle after enqueue.
        upd(1, 1, 32'h2000, 32'h0000_1008);
        step();
        upd(0, 0, 0, 0);
        @(negedge iCLOCK);
        chk("one_jump_stb", oBC_JUMP_STB, 1);
        chk("one_jump_addr", oBC_JUMP_ADDR, 32'h2000);
        chk("one_jump_inst", oBC_JUMP_INST_ADDR, 32'h1008);
        chk("one_jump_hit", oBC_JUMP_HIT, 1);
        step();
        @(negedge iCLOCK);
        chk("one_empty", oBC_JUMP_STB, 0);

        // Conflicting fetch held: 8 deferrals then a forced issue.
        iFETCH_REQ = 1; iFETCH_ADDR = 32'h0000_3008;
        upd(1, 0, 32'h2100, 32'h0000_1008);
        step();
        upd(0, 0, 0, 0);
        defers = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge iCLOCK);
            if (oBC_JUMP_STB) begin
                got = 1;
                chk("forced_search", oBC_SEARCH_STB, 0);
                chk("forced_stall", oFETCH_STALL, 1);
            end else if (oBC_SEARCH_STB) defers++;
        end
        chk("forced_seen", got, 1);
        chk("defer_count", defers, 8);
        step();
        iFETCH_REQ = 0;

        // Different set: issue and search together, no stall.
        upd(1, 0, 32'h4444, 32'h0000_2008);
        step();
        upd(0, 0, 0, 0);
        iFETCH_REQ = 1; iFETCH_ADDR = 32'h0000_000C;
        @(negedge iCLOCK);
        chk("nc_jump", oBC_JUMP_STB, 1);
        chk("nc_search", oBC_SEARCH_STB, 1);
        chk("nc_stall", oFETCH_STALL, 0);
        step();
        iFETCH_REQ = 0;

        // Five back-to-back updates against a continuously conflicting fetch.
        iFETCH_REQ = 1; iFETCH_ADDR = 32'h0000_3008;
        for (int k = 0; k < 5; k++) begin
            upd(1, k[0], 32'h5000 + k, 32'h0000_1008 + 32'h20 * k);
            step();
        end
        upd(1, 1, 32'h5555, 32'h0000_10A8);
        @(negedge iCLOCK);
        chk("ovf_busy", oEXE_UPD_BUSY, 1);
        chk("ovf_set", oUPD_OVERFLOW, 1);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge iCLOCK);
            if (oBC_JUMP_STB) got = 1;
        end
        chk("full_forced_seen", got, 1);
        chk("full_forced_busy", oEXE_UPD_BUSY, 1);
        step();
        upd(0, 0, 0, 0);
        @(negedge iCLOCK);
        chk("full_after_swap_busy", oEXE_UPD_BUSY, 1);
        chk("ovf_sticky", oUPD_OVERFLOW, 1);
        iFETCH_REQ = 0;
        repeat (6) step();

        // Flush for 3 cycles with 2 entries queued behind a conflicting fetch.
        iFETCH_REQ = 1; iFETCH_ADDR = 32'h0000_3008;
        upd(1, 0, 32'h6000, 32'h0000_1028); step();
        upd(1, 1, 32'h6001, 32'h0000_1048); step();
        upd(0, 0, 0, 0);
        iFLUSH = 1;
        fl_cyc = 0; jmp_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLOCK);
            fl_cyc += int'(oBC_FLUSH); jmp_cyc += int'(oBC_JUMP_STB);
            step();
        end
        iFLUSH = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge iCLOCK);
            fl_cyc += int'(oBC_FLUSH); jmp_cyc += int'(oBC_JUMP_STB);
            if (i == 0) step();
        end
        chk("flush_cycles", fl_cyc, 3);
        chk("flush_no_jump", jmp_cyc, 0);
        chk("flush_busy", oEXE_UPD_BUSY, 0);
        iFETCH_REQ = 0;
        upd(1, 1, 32'h7777, 32'h0000_1010);
        step();
        upd(0, 0, 0, 0);
        @(negedge iCLOCK);
        chk("post_flush_jump", oBC_JUMP_STB, 1);
        chk("post_flush_addr", oBC_JUMP_ADDR, 32'h7777);
        step();

        // Synchronous reset pulse discards a deferred head.
        iFETCH_REQ = 1; iFETCH_ADDR = 32'h0000_3008;
        upd(1, 0, 32'h8888, 32'h0000_1008); step();
        upd(0, 0, 0, 0);
        iRESET_SYNC = 1; step();
        iRESET_SYNC = 0;
        @(negedge iCLOCK);
        chk("rsync_flush", oBC_FLUSH, 1);
        chk("rsync_stall", oFETCH_STALL, 1);
        step();
        iFETCH_REQ = 0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard timeout so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
